// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared widths and FSM state encodings for the RAM arbiter
package ram_arb_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_RESP = 1'b1;

endpackage

// File: rtl/ram_arb_if.sv
// rtl/ram_arb_if.sv - per-requester command/response channel between a front-end and ram_arb
interface ram_arb_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/ram_arb_rr_arb2.sv
// rtl/ram_arb_rr_arb2.sv - combinational 2-way round-robin picker
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  // i_last is the index granted most recently; a tie goes to the other one
  assign o_gnt[0] = i_req[0] & (~i_req[1] |  i_last);
  assign o_gnt[1] = i_req[1] & (~i_req[0] | ~i_last);

endmodule

// File: rtl/ram_arb.sv
// rtl/ram_arb.sv - two-requester round-robin sequencer for the 1R1W data RAM, one txn in flight
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_arb_if.slave          m0,
  ram_arb_if.slave          m1,
  output logic [ADDR_W-1:0] o_ram_raddr,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic [ADDR_W-1:0] o_ram_waddr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_wen
);

  logic [0:0]        r_state;
  logic              r_last_grant;
  logic              r_owner;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0]        w_gnt_raw;
  logic [1:0]        w_gnt;
  logic              w_accept;
  logic              w_wen;
  logic              w_resp;
  logic              w_resp_done;

  rr_arb2 u_rr_arb2 (
    .i_req  ({m1.req_valid, m0.req_valid}),
    .i_last (r_last_grant),
    .o_gnt  (w_gnt_raw)
  );

  // rst_n gating keeps ready and write-enable low for the whole reset window
  assign w_gnt    = (r_state == ARB_IDLE && rst_n) ? w_gnt_raw : 2'b00;
  assign w_accept = |w_gnt;

  assign m0.req_ready = w_gnt[0];
  assign m1.req_ready = w_gnt[1];

  always_comb begin
    w_wen       = 1'b0;
    o_ram_raddr = '0;
    o_ram_waddr = '0;
    o_ram_wdata = '0;
    if (w_gnt[0]) begin
      w_wen       = m0.req_wen;
      o_ram_raddr = m0.req_addr;
      o_ram_waddr = m0.req_addr;
      o_ram_wdata = m0.req_wdata;
    end else if (w_gnt[1]) begin
      w_wen       = m1.req_wen;
      o_ram_raddr = m1.req_addr;
      o_ram_waddr = m1.req_addr;
      o_ram_wdata = m1.req_wdata;
    end
  end

  assign o_ram_wen = w_wen;

  assign w_resp      = (r_state == ARB_RESP);
  assign w_resp_done = w_resp & (r_owner ? m1.resp_ready : m0.resp_ready);

  assign m0.resp_valid = w_resp & ~r_owner;
  assign m1.resp_valid = w_resp &  r_owner;
  assign m0.resp_rdata = (w_resp & ~r_owner) ? r_rdata : '0;
  assign m1.resp_rdata = (w_resp &  r_owner) ? r_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_accept) begin
            r_owner <= w_gnt[1];
            r_rdata <= w_wen ? '0 : i_ram_rdata;
            r_state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (w_resp_done) begin
            r_last_grant <= r_owner;
            r_state      <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
// tb/tb_ram_arb.sv - directed self-checking bench for ram_arb with a behavioural 256x32 RAM
module tb_ram_arb;
  import ram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arb_if m0_if ();
  ram_arb_if m1_if ();

  logic [7:0]  ram_raddr;
  logic [7:0]  ram_waddr;
  logic [31:0] ram_rdata;
  logic [31:0] ram_wdata;
  logic        ram_wen;

  ram_arb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0          (m0_if),
    .m1          (m1_if),
    .o_ram_raddr (ram_raddr),
    .i_ram_rdata (ram_rdata),
    .o_ram_waddr (ram_waddr),
    .o_ram_wdata (ram_wdata),
    .o_ram_wen   (ram_wen)
  );

  logic [31:0] mem [0:RAM_DEPTH-1];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'h00;
  logic [31:0] pl_data = 32'h0;

  assign ram_rdata = mem[ram_raddr];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic drive_req(input bit m, input bit v, input bit wen, input logic [7:0] a, input logic [31:0] d);
    if (m) begin
      m1_if.req_valid = v; m1_if.req_wen = wen; m1_if.req_addr = a; m1_if.req_wdata = d;
    end else begin
      m0_if.req_valid = v; m0_if.req_wen = wen; m0_if.req_addr = a; m0_if.req_wdata = d;
    end
  endtask

  task automatic set_rr(input bit m, input bit r);
    if (m) m1_if.resp_ready = r;
    else   m0_if.resp_ready = r;
  endtask

  function automatic logic get_ready(input bit m);
    return m ? m1_if.req_ready : m0_if.req_ready;
  endfunction

  function automatic logic get_rv(input bit m);
    return m ? m1_if.resp_valid : m0_if.resp_valid;
  endfunction

  function automatic logic [31:0] get_rdata(input bit m);
    return m ? m1_if.resp_rdata : m0_if.resp_rdata;
  endfunction

  // Full single transaction on one port; reports accept wait, response presence and data
  task automatic txn(input bit m, input bit wen, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rdata, output bit acc_ok, output bit resp_ok, output int lat);
    int n;
    @(posedge clk); #1 drive_req(m, 1'b1, wen, a, d);
    @(negedge clk);
    n = 0;
    while (!get_ready(m) && n < 16) begin
      @(negedge clk);
      n++;
    end
    acc_ok = get_ready(m);
    lat = n;
    @(posedge clk); #1 drive_req(m, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    resp_ok = get_rv(m);
    rdata = get_rdata(m);
    set_rr(m, 1'b1);
    @(posedge clk); #1 set_rr(m, 1'b0);
  endtask

  task automatic test_reset;
    logic [7:0]  pa [5];
    logic [31:0] pd [5];
    logic [31:0] rd;
    bit acc, rsp;
    int lat;
    pa = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h30};
    pd = '{32'h0BADF00D, 32'h00000011, 32'h00000022, 32'h00000055, 32'h30303030};
    rst_n = 1'b0;
    drive_req(1'b0, 1'b1, 1'b1, 8'h40, 32'hFFFFFFFF);
    drive_req(1'b1, 1'b1, 1'b0, 8'h41, 32'h0);
    set_rr(1'b0, 1'b1); set_rr(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 pl_en = 1'b1; pl_addr = pa[i]; pl_data = pd[i];
    end
    @(posedge clk); #1 pl_en = 1'b0;
    @(negedge clk);
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL rst_wen got %b exp 0", ram_wen); end
    checks++; if ({m1_if.req_ready, m0_if.req_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", {m1_if.req_ready, m0_if.req_ready}); end
    checks++; if ({m1_if.resp_valid, m0_if.resp_valid} !== 2'b00) begin errors++; $display("FAIL rst_rv got %b exp 00", {m1_if.resp_valid, m0_if.resp_valid}); end
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    set_rr(1'b0, 1'b0); set_rr(1'b1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({m1_if.resp_valid, m0_if.resp_valid, ram_wen} !== 3'b000) begin errors++; $display("FAIL post_rst got %b exp 000", {m1_if.resp_valid, m0_if.resp_valid, ram_wen}); end
    txn(1'b1, 1'b0, 8'h05, 32'h0, rd, acc, rsp, lat);
    checks++; if (!acc || lat !== 0) begin errors++; $display("FAIL first_m1_accept got acc=%0d lat=%0d exp acc=1 lat=0", acc, lat); end
    checks++; if (!rsp || rd !== 32'h00000055) begin errors++; $display("FAIL first_m1_rdata got rv=%0d %h exp rv=1 00000055", rsp, rd); end
  endtask

  task automatic test_write_read;
    logic [31:0] rd;
    bit acc, rsp;
    int lat;
    @(posedge clk); #1 drive_req(1'b0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if ({m0_if.req_ready, ram_wen, ram_waddr, ram_wdata} !== {1'b1, 1'b1, 8'h10, 32'hDEADBEEF})
      begin errors++; $display("FAIL wr_ram_port got rdy=%b wen=%b %h %h exp 1 1 10 deadbeef", m0_if.req_ready, ram_wen, ram_waddr, ram_wdata); end
    @(posedge clk); #1 drive_req(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checks++; if ({m0_if.resp_valid, m1_if.resp_valid, ram_wen} !== 3'b100) begin errors++; $display("FAIL wr_resp_flags got %b exp 100", {m0_if.resp_valid, m1_if.resp_valid, ram_wen}); end
    checks++; if (m0_if.resp_rdata !== 32'h0) begin errors++; $display("FAIL wr_resp_rdata got %h exp 00000000", m0_if.resp_rdata); end
    set_rr(1'b0, 1'b1);
    @(posedge clk); #1 set_rr(1'b0, 1'b0);
    txn(1'b0, 1'b0, 8'h10, 32'h0, rd, acc, rsp, lat);
    checks++; if (!acc || !rsp || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_after_wr got acc=%0d rv=%0d %h exp 1 1 deadbeef", acc, rsp, rd); end
  endtask

  task automatic test_round_robin;
    logic [31:0] rd;
    bit acc, rsp;
    int lat;
    logic [1:0]  exp_rdy, exp_rv;
    logic [31:0] exp_d;
    txn(1'b1, 1'b0, 8'h02, 32'h0, rd, acc, rsp, lat);
    checks++; if (!acc || !rsp || rd !== 32'h00000022) begin errors++; $display("FAIL rr_prime got acc=%0d rv=%0d %h exp 1 1 00000022", acc, rsp, rd); end
    @(posedge clk); #1
    drive_req(1'b0, 1'b1, 1'b0, 8'h01, 32'h0);
    drive_req(1'b1, 1'b1, 1'b0, 8'h02, 32'h0);
    set_rr(1'b0, 1'b1); set_rr(1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_rdy = (k % 4 == 0) ? 2'b01 : (k % 4 == 2) ? 2'b10 : 2'b00;
      exp_rv  = (k % 4 == 1) ? 2'b01 : (k % 4 == 3) ? 2'b10 : 2'b00;
      checks++; if ({m1_if.req_ready, m0_if.req_ready} !== exp_rdy) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", k, {m1_if.req_ready, m0_if.req_ready}, exp_rdy); end
      checks++; if ({m1_if.resp_valid, m0_if.resp_valid} !== exp_rv) begin errors++; $display("FAIL rr_resp[%0d] got %b exp %b", k, {m1_if.resp_valid, m0_if.resp_valid}, exp_rv); end
      if (k % 2 == 1) begin
        exp_d = (k % 4 == 1) ? 32'h00000011 : 32'h00000022;
        rd = (k % 4 == 1) ? m0_if.resp_rdata : m1_if.resp_rdata;
        checks++; if (rd !== exp_d) begin errors++; $display("FAIL rr_rdata[%0d] got %h exp %h", k, rd, exp_d); end
      end
    end
    @(posedge clk); #1
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    set_rr(1'b0, 1'b0); set_rr(1'b1, 1'b0);
  endtask

  task automatic test_resp_stall;
    @(posedge clk); #1 drive_req(1'b1, 1'b1, 1'b0, 8'h02, 32'h0);
    @(negedge clk);
    checks++; if (m1_if.req_ready !== 1'b1) begin errors++; $display("FAIL stall_m1_accept got %b exp 1", m1_if.req_ready); end
    @(posedge clk); #1
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    drive_req(1'b0, 1'b1, 1'b0, 8'h01, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({m1_if.resp_valid, m1_if.resp_rdata} !== {1'b1, 32'h00000022}) begin errors++; $display("FAIL stall_hold[%0d] got rv=%b %h exp 1 00000022", c, m1_if.resp_valid, m1_if.resp_rdata); end
      checks++; if (m0_if.req_ready !== 1'b0) begin errors++; $display("FAIL stall_m0_blocked[%0d] got %b exp 0", c, m0_if.req_ready); end
      @(posedge clk); #1;
    end
    set_rr(1'b1, 1'b1);
    @(negedge clk);
    checks++; if (m0_if.req_ready !== 1'b0) begin errors++; $display("FAIL stall_no_accept_on_done got %b exp 0", m0_if.req_ready); end
    @(posedge clk); #1 set_rr(1'b1, 1'b0);
    @(negedge clk);
    checks++; if (m0_if.req_ready !== 1'b1) begin errors++; $display("FAIL stall_m0_granted got %b exp 1", m0_if.req_ready); end
    @(posedge clk); #1 drive_req(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    checks++; if ({m0_if.resp_valid, m0_if.resp_rdata} !== {1'b1, 32'h00000011}) begin errors++; $display("FAIL stall_m0_resp got rv=%b %h exp 1 00000011", m0_if.resp_valid, m0_if.resp_rdata); end
    set_rr(1'b0, 1'b1);
    @(posedge clk); #1 set_rr(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    bit acc, rsp;
    int lat;
    @(posedge clk); #1 drive_req(1'b0, 1'b1, 1'b1, 8'h20, 32'h12345678);
    @(negedge clk);
    checks++; if (m0_if.req_ready !== 1'b1) begin errors++; $display("FAIL mid_accept got %b exp 1", m0_if.req_ready); end
    @(posedge clk); #1 drive_req(1'b0, 1'b1, 1'b1, 8'h30, 32'hFFFFFFFF);
    @(negedge clk);
    checks++; if (m0_if.resp_valid !== 1'b1) begin errors++; $display("FAIL mid_resp_before got %b exp 1", m0_if.resp_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({m0_if.resp_valid, m0_if.req_ready, ram_wen} !== 3'b000) begin errors++; $display("FAIL mid_async_drop got %b exp 000", {m0_if.resp_valid, m0_if.req_ready, ram_wen}); end
    @(negedge clk);
    checks++; if (ram_wen !== 1'b0) begin errors++; $display("FAIL mid_wen_in_reset got %b exp 0", ram_wen); end
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({m1_if.resp_valid, m0_if.resp_valid} !== 2'b00) begin errors++; $display("FAIL mid_idle_after got %b exp 00", {m1_if.resp_valid, m0_if.resp_valid}); end
    txn(1'b0, 1'b0, 8'h30, 32'h0, rd, acc, rsp, lat);
    checks++; if (!acc || lat !== 0 || !rsp || rd !== 32'h30303030) begin errors++; $display("FAIL mid_no_write_in_reset got acc=%0d lat=%0d rv=%0d %h exp 1 0 1 30303030", acc, lat, rsp, rd); end
    txn(1'b0, 1'b0, 8'h20, 32'h0, rd, acc, rsp, lat);
    checks++; if (!acc || !rsp || rd !== 32'h12345678) begin errors++; $display("FAIL mid_write_kept got acc=%0d rv=%0d %h exp 1 1 12345678", acc, rsp, rd); end
  endtask

  task automatic test_addr_edge;
    logic [31:0] rd;
    bit acc, rsp;
    int lat;
    txn(1'b1, 1'b1, 8'hFF, 32'hA5A5A5A5, rd, acc, rsp, lat);
    checks++; if (!acc || !rsp || rd !== 32'h0) begin errors++; $display("FAIL edge_wr got acc=%0d rv=%0d %h exp 1 1 00000000", acc, rsp, rd); end
    txn(1'b0, 1'b0, 8'hFF, 32'h0, rd, acc, rsp, lat);
    checks++; if (!acc || !rsp || rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL edge_rd_ff got acc=%0d rv=%0d %h exp 1 1 a5a5a5a5", acc, rsp, rd); end
    txn(1'b0, 1'b0, 8'h00, 32'h0, rd, acc, rsp, lat);
    checks++; if (!acc || !rsp || rd !== 32'h0BADF00D) begin errors++; $display("FAIL edge_rd_00 got acc=%0d rv=%0d %h exp 1 1 0badf00d", acc, rsp, rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    set_rr(1'b0, 1'b0);
    set_rr(1'b1, 1'b0);
    test_reset();
    test_write_read();
    test_round_robin();
    test_resp_stall();
    test_reset_mid();
    test_addr_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
